// File: rtl/fifo_burst_drainer_pkg.sv
// fifo_burst_drainer_pkg: shared FSM encoding and output-buffer entry sizing
package fifo_burst_drainer_pkg;
  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] WAIT_ENC = 2'd1;
  localparam logic [1:0] DRAIN_ENC = 2'd2;
  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    WAIT = WAIT_ENC,
    DRAIN = DRAIN_ENC
  } state_t;
  function automatic int entry_width(input int width);
    return width + 1;
  endfunction
endpackage

// File: rtl/fifo_burst_drainer_skid_buffer.sv
// fifo_burst_drainer_skid_buffer: two-entry register FIFO with valid/ready head and sync clear
module fifo_burst_drainer_skid_buffer
  import fifo_burst_drainer_pkg::*;
#(
  parameter int EW = entry_width(8)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [EW-1:0] push_data,
  output logic          full,
  output logic          out_valid,
  output logic [EW-1:0] out_data,
  input  logic          out_ready
);
  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic rd_q, rd_d, wr_q, wr_d, pop;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    out_valid = cnt_q != 2'd0;
    full = cnt_q == 2'd2;
    out_data = out_valid ? mem_q[rd_q] : '0;
    pop = out_valid && out_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    rd_d = clear ? 1'b0 : rd_q ^ pop;
    wr_d = clear ? 1'b0 : wr_q ^ push;
    cnt_d = clear ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fifo_burst_drainer.sv
// fifo_burst_drainer: groups FIFO entries into threshold/timeout bursts and streams them out
module fifo_burst_drainer
  import fifo_burst_drainer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DEPTH_LOG2 = $clog2(DEPTH),
  parameter int TIMEOUT = 16,
  parameter int TIMEOUT_LOG2 = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  read_enable,
  input  logic [WIDTH-1:0]      read_data,
  input  logic                  read_empty,
  input  logic [DEPTH_LOG2:0]   read_level,
  input  logic [DEPTH_LOG2:0]   burst_threshold,
  output logic                  output_valid,
  output logic [WIDTH-1:0]      output_data,
  output logic                  output_last,
  input  logic                  output_ready,
  output logic                  busy
);
  localparam int EW = entry_width(WIDTH);
  localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [TIMEOUT_LOG2-1:0] TIMER_MAX = TIMEOUT_LOG2'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic [DEPTH_LOG2:0] remaining_q, remaining_d, thr;
  logic [TIMEOUT_LOG2-1:0] timer_q, timer_d;
  logic full, start;
  logic [EW-1:0] head;
  always_comb begin
    thr = (burst_threshold == '0) ? ONE : (burst_threshold > DEPTH_V) ? DEPTH_V : burst_threshold;
    start = read_level >= thr;
    read_enable = !flush && state_q == DRAIN && !read_empty && remaining_q != '0 && !full;
    state_d = state_q;
    remaining_d = remaining_q;
    timer_d = timer_q;
    if (flush) begin
      state_d = IDLE;
      remaining_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: if (!read_empty) begin
          state_d = start ? DRAIN : WAIT;
          remaining_d = start ? read_level : remaining_q;
          timer_d = '0;
        end
        WAIT: begin
          timer_d = timer_q + 1'b1;
          if (start || timer_q == TIMER_MAX) begin
            state_d = DRAIN;
            remaining_d = read_level;
          end
        end
        DRAIN: begin
          remaining_d = remaining_q - (DEPTH_LOG2 + 1)'(read_enable);
          // the zero check only guards against a snapshot taken from an empty FIFO
          if (remaining_q == '0 || (read_enable && remaining_q == ONE)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      remaining_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      timer_q <= timer_d;
    end
  end
  fifo_burst_drainer_skid_buffer #(.EW(EW)) u_buf (
    .clock(clock),
    .reset(reset),
    .clear(flush),
    .push(read_enable),
    .push_data({read_data, remaining_q == ONE}),
    .full(full),
    .out_valid(output_valid),
    .out_data(head),
    .out_ready(output_ready)
  );
  assign {output_data, output_last} = head;
  assign busy = state_q != IDLE || output_valid;
endmodule
